updown_counter_mod: RTL and testbench
=====================================

UPDOWN_COUNTER_MOD -- requirements
Module: updown_counter_mod

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: counter width in bits.
REQ-002 The block SHALL have parameter MOD_MAX, default 9: highest count value; legal range 1 .. 2^WIDTH-1.
REQ-003 The block SHALL have parameter SAT, default 0: 0 = wrap at boundary, 1 = saturate at boundary.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port en_i, input, 1 bit: count enable; one step per enabled cycle.
REQ-007 The block SHALL have port dir_i, input, 1 bit: 1 = count up, 0 = count down.
REQ-008 The block SHALL have port load_i, input, 1 bit: parallel load strobe.
REQ-009 The block SHALL have port value_i, input, WIDTH bits: load value.
REQ-010 The block SHALL have port count_o, output, WIDTH bits: current registered count.
REQ-011 The block SHALL have port tc_o, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-012 The block SHALL have port ovf_o, output, 1 bit: sticky boundary-crossing flag.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 Per-edge priority SHALL be: rst_i > load_i > en_i > hold.
REQ-015 On load_i=1, count_o SHALL take value_i on the next edge, regardless of en_i and dir_i.
REQ-016 On load_i=1 with value_i > MOD_MAX, count_o SHALL take MOD_MAX (clamp).
REQ-017 On load_i=1, ovf_o SHALL clear and tc_o SHALL be 0 on the next edge.
REQ-018 When en_i=1, dir_i=1 and count_o < MOD_MAX, count_o SHALL become count_o+1 on the next edge.
REQ-019 When en_i=1, dir_i=0 and count_o > 0, count_o SHALL become count_o-1 on the next edge.
REQ-020 Up-step at count_o=MOD_MAX SHALL produce 0 when SAT=0 and hold MOD_MAX when SAT=1.
REQ-021 Down-step at count_o=0 SHALL produce MOD_MAX when SAT=0 and hold 0 when SAT=1.
REQ-022 A boundary step (REQ-020 or REQ-021) SHALL set tc_o=1 for exactly the following cycle, in both SAT modes.
REQ-023 A boundary step SHALL set ovf_o=1; ovf_o SHALL stay 1 until rst_i or load_i.
REQ-024 tc_o SHALL be 0 in every cycle not directly following a boundary step.
REQ-025 With en_i=0 and load_i=0, count_o and ovf_o SHALL hold and tc_o SHALL be 0.
REQ-026 dir_i changes SHALL take effect on the very next enabled step, with no dead cycle.
REQ-027 Arithmetic SHALL be WIDTH bits wide; no intermediate value outside 0..MOD_MAX SHALL ever appear on count_o.
REQ-028 Elaboration SHALL fail if MOD_MAX > 2^WIDTH-1 or MOD_MAX < 1.

Reset
REQ-029 On rst_i=1 at an edge, count_o SHALL become 0, tc_o 0 and ovf_o 0, overriding load_i and en_i.
REQ-030 Reset asserted mid-count SHALL discard any pending step; counting resumes from 0 in the first enabled cycle after rst_i falls.

Verification (WIDTH=4, MOD_MAX=9 unless noted)
REQ-031 The bench SHALL cover: reset, then en_i=1, dir_i=1 for 12 cycles -> count_o 1..9,0,1,2; tc_o high only in the cycle count_o=0; ovf_o=1 from then on.
REQ-032 The bench SHALL cover: load value_i=3, then dir_i=0, en_i=1 for 5 cycles -> 3,2,1,0,9,8; tc_o pulses with the 9; load_i at 9 with value_i=14 -> count_o=9, ovf_o=0.
REQ-033 The bench SHALL cover: SAT=1, load 8, then up for 3 cycles -> 9,9,9; tc_o pulses twice (after each step at 9); count_o never 0.
REQ-034 The bench SHALL cover: load_i=1 and en_i=1 in the same cycle with value_i=5, dir_i=1 -> count_o=5, not 6.
REQ-035 The bench SHALL cover: rst_i=1 with load_i=1 and value_i=7 at count_o=4 -> count_o=0, ovf_o=0, tc_o=0.
REQ-036 The bench SHALL cover: WIDTH=8, MOD_MAX=255, up from 254 for 3 cycles -> 255,0,1 with a single tc_o pulse.

Source files
------------

// File: rtl/updown_counter_mod.sv
// Modulo-(MOD_MAX+1) up/down counter with parallel load, a terminal-count pulse
// and a sticky overflow flag; SAT selects wrap or saturate at either boundary.
module updown_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MOD_MAX = 9,
    parameter bit SAT     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             ovf_o
);

    if (MOD_MAX < 1 || MOD_MAX > (2 ** WIDTH) - 1) begin : g_bad_mod_max
        $error("updown_counter_mod: MOD_MAX must lie in 1 .. 2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MaxVal  = MOD_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZeroVal = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    // Load beats stepping; a step at either boundary wraps or saturates and flags it.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (load_i) begin
            count_d = (value_i > MaxVal) ? MaxVal : value_i;
            ovf_d   = 1'b0;
        end else if (en_i) begin
            if (dir_i) begin
                if (count_q >= MaxVal) begin
                    count_d = SAT ? MaxVal : ZeroVal;
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == ZeroVal) begin
                    count_d = SAT ? ZeroVal : MaxVal;
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: a wrapping 4-bit mod-10 counter, a
// saturating one sharing its inputs, and an 8-bit mod-256 counter.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       rst, en, dir, load;
    logic [3:0] value;
    logic [3:0] cnt, cntSat;
    logic       tc, tcSat, ovf, ovfSat;

    logic       rst8, en8, dir8, load8;
    logic [7:0] value8, cnt8;
    logic       tc8, ovf8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(4), .MOD_MAX(9), .SAT(1'b0)) dutWrap (
        .clk(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
        .value_i(value), .count_o(cnt), .tc_o(tc), .ovf_o(ovf)
    );

    updown_counter_mod #(.WIDTH(4), .MOD_MAX(9), .SAT(1'b1)) dutSat (
        .clk(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .load_i(load),
        .value_i(value), .count_o(cntSat), .tc_o(tcSat), .ovf_o(ovfSat)
    );

    updown_counter_mod #(.WIDTH(8), .MOD_MAX(255), .SAT(1'b0)) dutWide (
        .clk(clk), .rst_i(rst8), .en_i(en8), .dir_i(dir8), .load_i(load8),
        .value_i(value8), .count_o(cnt8), .tc_o(tc8), .ovf_o(ovf8)
    );

    // Inputs change 1 time unit after a rising edge; outputs are read at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic d,
                         input logic l, input logic [3:0] v);
        rst = r; en = e; dir = d; load = l; value = v;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
        rst8 = 1'b1; en8 = 1'b1; dir8 = 1'b1; load8 = 1'b0; value8 = 8'd0;
        tick();
        tick();
        total++; if (cnt !== 4'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", cnt); end
        total++; if (tc !== 1'b0) begin bad++; $display("[TB] FAIL reset_tc: got %0b expected 0", tc); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %0b expected 0", ovf); end
        total++; if (cntSat !== 4'd0) begin bad++; $display("[TB] FAIL reset_count_sat: got %0d expected 0", cntSat); end
        total++; if (cnt8 !== 8'd0) begin bad++; $display("[TB] FAIL reset_count_wide: got %0d expected 0", cnt8); end
        rst8 = 1'b0; en8 = 1'b0;
    endtask

    task automatic test_count_up();
        int expCount[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (cnt !== expCount[i][3:0] || tc !== (i == 9) || ovf !== (i >= 9)) begin
                bad++;
                $display("[TB] FAIL up_step%0d: got count=%0d tc=%0b ovf=%0b expected count=%0d tc=%0b ovf=%0b",
                         i, cnt, tc, ovf, expCount[i], (i == 9), (i >= 9));
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (cnt !== 4'd2 || tc !== 1'b0 || ovf !== 1'b1) begin
                bad++;
                $display("[TB] FAIL hold%0d: got count=%0d tc=%0b ovf=%0b expected count=2 tc=0 ovf=1",
                         i, cnt, tc, ovf);
            end
        end
    endtask

    task automatic test_count_down();
        int expCount[5] = '{2, 1, 0, 9, 8};
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
        tick();
        total++;
        if (cnt !== 4'd3 || ovf !== 1'b0 || tc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL load3: got count=%0d tc=%0b ovf=%0b expected count=3 tc=0 ovf=0", cnt, tc, ovf);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (cnt !== expCount[i][3:0] || tc !== (i == 3) || ovf !== (i >= 3)) begin
                bad++;
                $display("[TB] FAIL down_step%0d: got count=%0d tc=%0b ovf=%0b expected count=%0d tc=%0b ovf=%0b",
                         i, cnt, tc, ovf, expCount[i], (i == 3), (i >= 3));
            end
        end
        // Direction flips straight from down to up with no dead cycle.
        dir = 1'b1;
        tick();
        total++;
        if (cnt !== 4'd9 || tc !== 1'b0 || ovf !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dir_flip: got count=%0d tc=%0b ovf=%0b expected count=9 tc=0 ovf=1", cnt, tc, ovf);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd14);
        tick();
        total++;
        if (cnt !== 4'd9 || tc !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL load_clamp: got count=%0d tc=%0b ovf=%0b expected count=9 tc=0 ovf=0", cnt, tc, ovf);
        end
    endtask

    task automatic test_saturate();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd8);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (cntSat !== 4'd9 || tcSat !== (i >= 1) || ovfSat !== (i >= 1)) begin
                bad++;
                $display("[TB] FAIL sat_up%0d: got count=%0d tc=%0b ovf=%0b expected count=9 tc=%0b ovf=%0b",
                         i, cntSat, tcSat, ovfSat, (i >= 1), (i >= 1));
            end
        end
        en = 1'b0;
        tick();
        total++;
        if (cntSat !== 4'd9 || tcSat !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sat_idle: got count=%0d tc=%0b expected count=9 tc=0", cntSat, tcSat);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        total++;
        if (cntSat !== 4'd0 || tcSat !== 1'b1 || ovfSat !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sat_down: got count=%0d tc=%0b ovf=%0b expected count=0 tc=1 ovf=1",
                     cntSat, tcSat, ovfSat);
        end
    endtask

    task automatic test_load_priority();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
        tick();
        total++;
        if (cnt !== 4'd5 || tc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL load_over_en: got count=%0d tc=%0b expected count=5 tc=0", cnt, tc);
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (cnt !== 4'd4 || ovf !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pre_reset: got count=%0d ovf=%0b expected count=4 ovf=1", cnt, ovf);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
        tick();
        total++;
        if (cnt !== 4'd0 || ovf !== 1'b0 || tc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_over_load: got count=%0d tc=%0b ovf=%0b expected count=0 tc=0 ovf=0",
                     cnt, tc, ovf);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        total++;
        if (cnt !== 4'd1) begin
            bad++;
            $display("[TB] FAIL resume_after_rst: got count=%0d expected 1", cnt);
        end
    endtask

    task automatic test_wide();
        int expCount[3] = '{255, 0, 1};
        load8 = 1'b1; value8 = 8'd254; en8 = 1'b0; dir8 = 1'b1;
        tick();
        load8 = 1'b0; en8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (cnt8 !== expCount[i][7:0] || tc8 !== (i == 1) || ovf8 !== (i >= 1)) begin
                bad++;
                $display("[TB] FAIL wide_step%0d: got count=%0d tc=%0b ovf=%0b expected count=%0d tc=%0b ovf=%0b",
                         i, cnt8, tc8, ovf8, expCount[i], (i == 1), (i >= 1));
            end
        end
        en8 = 1'b0;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        rst8 = 1'b1; en8 = 1'b0; dir8 = 1'b0; load8 = 1'b0; value8 = 8'd0;
        #1;
        test_reset();
        test_count_up();
        test_hold();
        test_count_down();
        test_saturate();
        test_load_priority();
        test_reset_priority();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
